// File: rtl/stage_mul_pipe_pkg.sv
// stage_mul_pipe_pkg: RV32M multiply encodings, op select enum and default pipe depth.
package stage_mul_pipe_pkg;
  localparam int OPCODE_SIZE = 7;
  localparam int FUNCT7_SIZE = 7;
  localparam int FUNCT3_SIZE = 3;
  localparam logic [OPCODE_SIZE-1:0] OPCODE_OP = 7'b0110011;
  localparam logic [FUNCT7_SIZE-1:0] F7_MULDIV = 7'b0000001;
  localparam logic [FUNCT3_SIZE-1:0] F3_MUL = 3'b000;
  localparam logic [FUNCT3_SIZE-1:0] F3_MULH = 3'b001;
  localparam logic [FUNCT3_SIZE-1:0] F3_MULHSU = 3'b010;
  localparam logic [FUNCT3_SIZE-1:0] F3_MULHU = 3'b011;
  localparam int DEF_MUL_STAGES = 5;
  typedef enum logic [1:0] {MUL_LO, MUL_HSS, MUL_HSU, MUL_HUU} mul_op_e;
endpackage

// File: rtl/mul_operand_ext.sv
// mul_operand_ext: funct3 to mul_op_e decode plus sign/zero extension of both operands to WD_SIZE+1 bits.
module mul_operand_ext
  import stage_mul_pipe_pkg::*;
#(
  parameter int WD_SIZE = 32
) (
  input  logic [1:0]         funct3,
  input  logic [WD_SIZE-1:0] op1,
  input  logic [WD_SIZE-1:0] op2,
  output mul_op_e            op,
  output logic [WD_SIZE:0]   op1_ext,
  output logic [WD_SIZE:0]   op2_ext
);
  always_comb begin
    op = funct3 == F3_MULH[1:0] ? MUL_HSS :
         funct3 == F3_MULHSU[1:0] ? MUL_HSU :
         funct3 == F3_MULHU[1:0] ? MUL_HUU : MUL_LO;
    op1_ext = {op == MUL_HUU ? 1'b0 : op1[WD_SIZE-1], op1};
    op2_ext = {(op == MUL_LO || op == MUL_HSS) ? op2[WD_SIZE-1] : 1'b0, op2};
  end
endmodule

// File: rtl/stage_mul_pipe.sv
// stage_mul_pipe: fully pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU) with tag, stall and flush.
// Define MUL_PERF_CNT_EN to add issued/flushed performance counters.
module stage_mul_pipe
  import stage_mul_pipe_pkg::*;
#(
  parameter int WD_SIZE    = 32,
  parameter int MUL_STAGES = DEF_MUL_STAGES,
  parameter int TAG_SIZE   = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
`ifdef MUL_PERF_CNT_EN
  output logic [31:0]            perf_mul_issued_o,
  output logic [31:0]            perf_mul_flushed_o,
`endif
  input  logic                   valid_i,
  input  logic [OPCODE_SIZE-1:0] opcode_i,
  input  logic [FUNCT7_SIZE-1:0] funct7_i,
  input  logic [FUNCT3_SIZE-1:0] funct3_i,
  input  logic [WD_SIZE-1:0]     op1_data_i,
  input  logic [WD_SIZE-1:0]     op2_data_i,
  input  logic [TAG_SIZE-1:0]    tag_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  output logic                   ready_o,
  output logic                   valid_o,
  output logic [WD_SIZE-1:0]     mult_result_o,
  output logic [TAG_SIZE-1:0]    tag_o,
  output logic                   busy_o
);
  logic hit;
  mul_op_e op_d, op_q;
  logic [WD_SIZE:0] a_d, b_d, a_q, b_q;
  logic signed [2*WD_SIZE-1:0] prod;
  logic [WD_SIZE-1:0] res_d;
  logic [MUL_STAGES:1] vld;
  logic [TAG_SIZE-1:0] tag_q [1:MUL_STAGES];
  logic [WD_SIZE-1:0] res_q [2:MUL_STAGES];

  mul_operand_ext #(.WD_SIZE(WD_SIZE)) u_ext (
    .funct3  (funct3_i[1:0]),
    .op1     (op1_data_i),
    .op2     (op2_data_i),
    .op      (op_d),
    .op1_ext (a_d),
    .op2_ext (b_d)
  );

  // Low 2*WD_SIZE bits of the signed product are exact, so the top two bits are never formed.
  always_comb begin
    hit = valid_i && opcode_i == OPCODE_OP && funct7_i == F7_MULDIV && !funct3_i[2];
    prod = $signed({{(WD_SIZE-1){a_q[WD_SIZE]}}, a_q}) * $signed({{(WD_SIZE-1){b_q[WD_SIZE]}}, b_q});
    res_d = op_q == MUL_LO ? prod[WD_SIZE-1:0] : prod[2*WD_SIZE-1:WD_SIZE];
    ready_o = !stall_i;
    valid_o = vld[MUL_STAGES];
    mult_result_o = res_q[MUL_STAGES];
    tag_o = tag_q[MUL_STAGES];
    busy_o = |vld;
  end

  always_ff @(posedge clk)
    if (reset_n && !flush_i && !stall_i && hit) begin
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
    end

  // Data registers load only behind a valid op so the output holds its last result.
  always_ff @(posedge clk)
    if (!reset_n) begin
      vld <= '0;
      for (int i = 1; i <= MUL_STAGES; i++) tag_q[i] <= '0;
      for (int i = 2; i <= MUL_STAGES; i++) res_q[i] <= '0;
    end else if (flush_i) begin
      vld <= '0;
    end else if (!stall_i) begin
      vld <= {vld[MUL_STAGES-1:1], hit};
      if (hit) tag_q[1] <= tag_i;
      if (vld[1]) res_q[2] <= res_d;
      for (int i = 2; i <= MUL_STAGES; i++)
        if (vld[i-1]) tag_q[i] <= tag_q[i-1];
      for (int i = 3; i <= MUL_STAGES; i++)
        if (vld[i-1]) res_q[i] <= res_q[i-1];
    end

`ifdef MUL_PERF_CNT_EN
  logic [31:0] kill_cnt;

  always_comb begin
    kill_cnt = '0;
    for (int i = 1; i <= MUL_STAGES; i++) kill_cnt = kill_cnt + 32'(vld[i]);
  end

  always_ff @(posedge clk)
    if (!reset_n) begin
      perf_mul_issued_o <= '0;
      perf_mul_flushed_o <= '0;
    end else if (flush_i) begin
      perf_mul_flushed_o <= perf_mul_flushed_o + kill_cnt;
    end else if (!stall_i && hit) begin
      perf_mul_issued_o <= perf_mul_issued_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_stage_mul_pipe.sv
// tb_stage_mul_pipe: scoreboard bench for stage_mul_pipe with directed and randomized traffic.
module tb_stage_mul_pipe;
  localparam int MS = 5;
  localparam logic [6:0] OP = 7'b0110011;
  localparam logic [6:0] F7M = 7'b0000001;

  logic clk = 1'b0;
  logic reset_n, valid_i, stall_i, flush_i;
  logic [6:0] opcode_i, funct7_i;
  logic [2:0] funct3_i;
  logic [31:0] op1_data_i, op2_data_i;
  logic [4:0] tag_i;
  logic ready_o, valid_o, busy_o;
  logic [31:0] mult_result_o;
  logic [4:0] tag_o;

  int errors = 0, checks = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          age;
  } exp_t;
  exp_t q[$];

  stage_mul_pipe #(.WD_SIZE(32), .MUL_STAGES(MS), .TAG_SIZE(5)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .valid_i       (valid_i),
    .opcode_i      (opcode_i),
    .funct7_i      (funct7_i),
    .funct3_i      (funct3_i),
    .op1_data_i    (op1_data_i),
    .op2_data_i    (op2_data_i),
    .tag_i         (tag_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .ready_o       (ready_o),
    .valid_o       (valid_o),
    .mult_result_o (mult_result_o),
    .tag_o         (tag_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ua = {32'b0, a};
    longint ub = {32'b0, b};
    longint p = f == 2'd3 ? ua * ub : f == 2'd2 ? sa * ub : sa * sb;
    return f == 2'd0 ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted op ages one step per advancing edge and is due at age MS.
  always @(posedge clk) begin
    if (!reset_n || flush_i) q.delete();
    else if (!stall_i) begin
      if (q.size() > 0 && q[0].age == MS) void'(q.pop_front());
      foreach (q[i]) q[i].age = q[i].age + 1;
      if (valid_i && opcode_i == OP && funct7_i == F7M && !funct3_i[2])
        q.push_back('{ref_mul(funct3_i[1:0], op1_data_i, op2_data_i), tag_i, 1});
    end
  end

  always @(negedge clk) begin
    logic exp_v;
    if (reset_n) begin
      exp_v = q.size() > 0 && q[0].age == MS;
      chk("mon_valid", valid_o, exp_v);
      chk("mon_busy", busy_o, q.size() != 0);
      chk("mon_ready", ready_o, !stall_i);
      if (valid_o && exp_v) begin
        chk("mon_result", mult_result_o, q[0].res);
        chk("mon_tag", tag_o, q[0].tag);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = 0; stall_i = 0; flush_i = 0;
    opcode_i = OP; funct7_i = F7M; funct3_i = 3'd0;
  endtask

  task automatic op_go(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    valid_i = 1; opcode_i = OP; funct7_i = f7; funct3_i = f3;
    op1_data_i = a; op2_data_i = b; tag_i = t;
    tick();
    valid_i = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (busy_o && n < 60) begin
      tick();
      n++;
    end
    chk("drain_busy", busy_o, 0);
    tick();
  endtask

  task automatic no_valid_for(input string name, input int n);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      cnt += int'(valid_o);
      tick();
    end
    chk(name, cnt, 0);
  endtask

  task automatic kat(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    op_go(F7M, f3, a, b, 5'd9);
    drain();
    chk(name, mult_result_o, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    idle();
    reset_n = 0; op1_data_i = 0; op2_data_i = 0; tag_i = 0;
    repeat (3) tick();
    reset_n = 1;
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_result", mult_result_o, 0);
    chk("rst_tag", tag_o, 0);
    tick();

    op_go(F7M, 3'b000, 32'd7, 32'd6, 5'd3);
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      if (valid_o) lat = n;
      else begin
        chk("lat_busy", busy_o, 1);
        tick();
      end
    end
    chk("latency", lat, MS);
    chk("mul_7x6", mult_result_o, 32'd42);
    chk("mul_7x6_tag", tag_o, 5'd3);
    drain();

    kat("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    kat("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    kat("mulhsu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    kat("mul_min_x2", 3'b000, 32'h8000_0000, 32'd2, 32'h0000_0000);

    for (int i = 1; i <= 5; i++) op_go(F7M, 3'b000, i, i, 5'(i));
    for (int k = 1; k <= 5; k++) begin
      chk("b2b_valid", valid_o, 1);
      chk("b2b_result", mult_result_o, k * k);
      chk("b2b_tag", tag_o, k);
      tick();
    end
    chk("b2b_end", valid_o, 0);
    drain();

    op_go(F7M, 3'b000, 32'd3, 32'd3, 5'd7);
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      if (valid_o) lat = n;
      else begin
        stall_i = (n == 3 || n == 4);
        tick();
      end
    end
    chk("stall_latency", lat, 7);
    stall_i = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold_valid", valid_o, 1);
      chk("stall_hold_result", mult_result_o, 32'd9);
    end
    stall_i = 0;
    tick();
    chk("stall_release", valid_o, 0);
    drain();

    for (int i = 0; i < 3; i++) op_go(F7M, 3'b000, 32'd11 + i, 32'd5, 5'(20 + i));
    valid_i = 1; flush_i = 1;
    tick();
    idle();
    chk("flush_valid", valid_o, 0);
    chk("flush_busy", busy_o, 0);
    no_valid_for("flush_no_valid", 12);

    for (int i = 0; i < 3; i++) op_go(F7M, 3'b000, 32'd13 + i, 32'd3, 5'(24 + i));
    valid_i = 1; reset_n = 0;
    tick();
    idle();
    reset_n = 1;
    chk("rstmid_valid", valid_o, 0);
    chk("rstmid_busy", busy_o, 0);
    chk("rstmid_result", mult_result_o, 0);
    chk("rstmid_tag", tag_o, 0);
    no_valid_for("rstmid_no_valid", 12);

    op_go(7'b0000000, 3'b000, 32'd4, 32'd4, 5'd1);
    chk("add_busy", busy_o, 0);
    no_valid_for("add_no_valid", 10);

    for (int i = 0; i < 400; i++) begin
      valid_i = ($urandom % 4) != 0;
      opcode_i = ($urandom % 16 == 0) ? 7'b0010011 : OP;
      funct7_i = ($urandom % 16 == 0) ? 7'b0000000 : F7M;
      funct3_i = {($urandom % 8 == 0), 2'($urandom)};
      op1_data_i = pick();
      op2_data_i = pick();
      tag_i = 5'($urandom);
      stall_i = ($urandom % 8) == 0;
      flush_i = ($urandom % 40) == 0;
      tick();
    end
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
